seg_mux_scheduler: RTL and testbench
====================================

Name: seg_mux_scheduler

Overview:
Time-multiplexing controller for the multi-digit seven-segment display. It shares the single hex-to-segment decoder between NUM_DIGITS digits by sequencing slot selection and common-anode enables. A blanking interval between slots suppresses ghosting. Digit values are loaded atomically at frame boundaries through a req/ack handshake, so a displayed frame never mixes old and new values.

Parameters:
NUM_DIGITS, 2, number of multiplexed digits (>=2)
DWELL_CYCLES, 25000, clk cycles each digit is driven per slot (>=2)
BLANK_CYCLES, 250, clk cycles all anodes are off before each slot (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
upd_req  in  1  level request to load new digit values
upd_vals  in  4*NUM_DIGITS  new hex values; digit i occupies bits [4i+3:4i]
en_mask  in  NUM_DIGITS  per-digit enable; 0 means the slot runs dark
upd_ack  out  1  one-cycle pulse: upd_vals captured into the shadow register
hex_out  out  4  nibble to the shared segment decoder
anode_n  out  NUM_DIGITS  active-low digit enables, at most one low
slot_idx  out  $clog2(NUM_DIGITS)  current slot index
frame_done  out  1  one-cycle pulse at the end of each full frame

Behaviour:
- Clock and reset: clock is clk; reset is synchronous, active-low (reset==0 at a posedge resets). Reset takes priority over all other activity, including mid-slot and mid-handshake.
- Reset values: state=S_BLANK, cnt=0, idx=0, shadow=0, anode_n=all 1s, hex_out=0, slot_idx=0, upd_ack=0, frame_done=0.
- States: S_BLANK and S_DRIVE. A single counter cnt tracks time in the current state.
- S_BLANK:
  - anode_n is all 1s; hex_out=shadow[idx] (pre-driven).
  - cnt increments each cycle. When cnt==BLANK_CYCLES-1: cnt<=0 and state<=S_DRIVE.
- S_DRIVE:
  - hex_out=shadow[idx].
  - anode_n[idx]=~en_mask[idx]; all other anode bits are 1.
  - en_mask is sampled combinationally, so a mask change takes effect the same cycle.
  - When cnt==DWELL_CYCLES-1: cnt<=0, state<=S_BLANK, and idx advances (NUM_DIGITS-1 wraps to 0).
- Disabled digits keep their slot, dark. Per-digit duty cycle is therefore constant regardless of the mask; no slot is ever skipped. All digits disabled gives all anodes off, with timing unchanged.
- Frame period is exactly NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles.
- Frame boundary: the S_DRIVE->S_BLANK transition with idx==NUM_DIGITS-1.
  - Registered frame_done is 1 for exactly the first cycle of the following S_BLANK.
  - If upd_req==1 at the boundary edge: shadow<=upd_vals on that edge, and upd_ack is 1 in the next cycle only.
  - upd_req is ignored at every other time.
  - The requester holds upd_vals stable while upd_req is high and drops upd_req after seeing upd_ack. If upd_req is still high at the next boundary, a fresh load occurs (not an error).
- Outputs hex_out, anode_n and slot_idx are registered or derived from registered state only, except for the en_mask gating described above.
- Counter width is $clog2(max(DWELL_CYCLES,BLANK_CYCLES)). No overflow is possible, since the terminal compare resets cnt.

Decomposition:
- Package seg_mux_pkg:
  - state typedef enum {S_BLANK, S_DRIVE}
  - localparam HEX_W=4
  - function next_idx(idx, n) for wrap-around
- Sub-module slot_timer: loadable up-counter with terminal-count compare input and tc output. It is reused for both states by muxing the compare value (BLANK_CYCLES-1 or DWELL_CYCLES-1).

Test Plan:
Bench settings: NUM_DIGITS=2, DWELL_CYCLES=4, BLANK_CYCLES=2, frame=12 cycles.
- Reset release, en_mask=2'b11, no update -> cycles 0-1 anode_n=11; cycles 2-5 anode_n=10, hex_out=0; cycles 6-7 anode_n=11; cycles 8-11 anode_n=01; frame_done=1 at cycle 12 only.
- upd_req=1 with upd_vals=8'hA5 from cycle 3 -> shadow unchanged until the boundary edge at end of cycle 11; upd_ack=1 at cycle 12; next frame shows hex_out=5 in slot 0 and A in slot 1.
- upd_req held high across two frames, upd_vals changed to 8'h3C between them -> two upd_ack pulses 12 cycles apart; second frame shows 3C.
- en_mask=2'b01 -> slot 1 period keeps anode_n=11 for all 4 cycles; frame period stays 12; slot 0 unaffected.
- reset=0 asserted mid-S_DRIVE of slot 1 with upd_req high -> next cycle matches all reset values: anode_n=11, idx=0, shadow=0, no upd_ack.
- 100 frames random en_mask/upd_req -> anode_n never has two bits low; anodes all high in every S_BLANK cycle; frame_done spacing always 12.

Source files
------------

// File: rtl/seg_mux_pkg.sv
// Shared types and helpers for the seven-segment multiplex scheduler.
package seg_mux_pkg;

  localparam int HEX_W = 4;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  // Advance a slot index with wrap-around at n.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Up-counter with a terminal-count compare; restarts at zero on terminal count.
// One instance times both blanking and drive phases by switching the compare.
module slot_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cmp,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == cmp);

  // Count up each cycle, wrap to zero when the compare value is reached.
  always_ff @(posedge clk) begin
    if (!reset)  cnt <= '0;
    else if (tc) cnt <= '0;
    else         cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/seg_mux_scheduler.sv
// Time-multiplexes one hex-to-segment decoder across NUM_DIGITS digits.
// Each slot is a blanking gap followed by a drive window; digit values are
// swapped in only at frame boundaries so a frame never mixes old and new data.
module seg_mux_scheduler
  import seg_mux_pkg::*;
#(
  parameter int NUM_DIGITS   = 2,
  parameter int DWELL_CYCLES = 25000,
  parameter int BLANK_CYCLES = 250
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          upd_req,
  input  logic [HEX_W*NUM_DIGITS-1:0]   upd_vals,
  input  logic [NUM_DIGITS-1:0]         en_mask,
  output logic                          upd_ack,
  output logic [HEX_W-1:0]              hex_out,
  output logic [NUM_DIGITS-1:0]         anode_n,
  output logic [$clog2(NUM_DIGITS)-1:0] slot_idx,
  output logic                          frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int MAX_C = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CNT_W = $clog2(MAX_C);

  state_t                               state;
  logic [IDX_W-1:0]                     idx;
  logic [NUM_DIGITS-1:0][HEX_W-1:0]     shadow;
  logic [CNT_W-1:0]                     cmp;
  logic                                 tc;
  logic                                 boundary;

  // Compare value follows the current phase so one timer serves both.
  assign cmp = (state == S_DRIVE) ? CNT_W'(DWELL_CYCLES - 1) : CNT_W'(BLANK_CYCLES - 1);

  slot_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .cmp   (cmp),
    .tc    (tc)
  );

  // Frame ends when the last slot's drive window expires.
  assign boundary = (state == S_DRIVE) && tc && (idx == IDX_W'(NUM_DIGITS - 1));

  // Phase sequencing, slot advance, and the frame-aligned shadow load.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_BLANK;
      idx        <= '0;
      shadow     <= '0;
      upd_ack    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      upd_ack    <= boundary && upd_req;
      if (boundary && upd_req) shadow <= upd_vals;
      if (tc) begin
        case (state)
          S_BLANK: state <= S_DRIVE;
          S_DRIVE: begin
            state <= S_BLANK;
            idx   <= IDX_W'(next_idx(32'(idx), NUM_DIGITS));
          end
          default: state <= S_BLANK;
        endcase
      end
    end
  end

  assign hex_out  = shadow[idx];
  assign slot_idx = idx;

  // Only the active slot may pull its anode low; mask gates it immediately.
  always_comb begin
    anode_n = '1;
    if (state == S_DRIVE) anode_n[idx] = ~en_mask[idx];
  end

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Self-checking bench: a time-based reference model (position within frame
// computed from the cycle count since reset) predicts every output.
module tb_seg_mux_scheduler;

  localparam int ND    = 2;
  localparam int DW    = 4;
  localparam int BL    = 2;
  localparam int SLOT  = DW + BL;
  localparam int FRAME = ND * SLOT;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            upd_req = 1'b0;
  logic [4*ND-1:0] upd_vals = '0;
  logic [ND-1:0]   en_mask = '1;
  logic            upd_ack;
  logic [3:0]      hex_out;
  logic [ND-1:0]   anode_n;
  logic [0:0]      slot_idx;
  logic            frame_done;

  int total = 0;
  int bad   = 0;

  // model state
  int              t = 0;
  int              gcyc = 0;
  int              last_fd = -1;
  logic [4*ND-1:0] sh_m = '0;
  logic            ack_m = 1'b0;
  logic            fd_m = 1'b0;

  seg_mux_scheduler #(.NUM_DIGITS(ND), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
    .clk        (clk),
    .reset      (reset),
    .upd_req    (upd_req),
    .upd_vals   (upd_vals),
    .en_mask    (en_mask),
    .upd_ack    (upd_ack),
    .hex_out    (hex_out),
    .anode_n    (anode_n),
    .slot_idx   (slot_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  // Check the current cycle against the model, then advance one clock edge.
  task automatic step();
    int p, s;
    logic drive;
    logic [ND-1:0] ea;
    #1;
    p = t % FRAME;
    s = p / SLOT;
    drive = (p % SLOT) >= BL;
    ea = '1;
    if (drive && en_mask[s]) ea[s] = 1'b0;
    chk("anode_n",    32'(anode_n),    32'(ea));
    chk("hex_out",    32'(hex_out),    32'(sh_m[s*4 +: 4]));
    chk("slot_idx",   32'(slot_idx),   32'(s));
    chk("frame_done", 32'(frame_done), 32'(fd_m));
    chk("upd_ack",    32'(upd_ack),    32'(ack_m));
    chk("one_low",    32'($countones(~anode_n) <= 1), 32'd1);
    if (frame_done) begin
      if (last_fd >= 0) chk("fd_gap", 32'(gcyc - last_fd), 32'(FRAME));
      last_fd = gcyc;
    end
    if (!reset) begin
      t = 0; sh_m = '0; ack_m = 1'b0; fd_m = 1'b0; last_fd = -1;
    end else begin
      fd_m  = (p == FRAME - 1);
      ack_m = fd_m && upd_req;
      if (ack_m) sh_m = upd_vals;
      t++;
    end
    @(posedge clk); #1;
    gcyc++;
  endtask

  initial begin
    @(posedge clk); #1;
    // held in reset
    repeat (3) step();
    reset = 1'b1;
    // idle frames, all digits enabled, zero values
    repeat (2 * FRAME) step();
    // single update request mid-frame, dropped after ack
    while (t % FRAME != 3) step();
    upd_req = 1'b1; upd_vals = 8'hA5;
    repeat (2 * FRAME) begin
      step();
      if (upd_ack) upd_req = 1'b0;
    end
    // request held across two frames, values changed after first ack
    upd_req = 1'b1; upd_vals = 8'h11;
    begin
      int acks = 0;
      for (int i = 0; i < 3 * FRAME && acks < 2; i++) begin
        step();
        if (upd_ack) begin
          acks++;
          if (acks == 1) upd_vals = 8'h3C;
          else upd_req = 1'b0;
        end
      end
      chk("held_acks", 32'(acks), 32'd2);
    end
    repeat (FRAME) step();
    // slot 1 disabled
    en_mask = 2'b01;
    repeat (2 * FRAME) step();
    en_mask = 2'b11;
    // reset during slot 1 drive with a pending request
    while (t % FRAME != 8) step();
    upd_req = 1'b1; upd_vals = 8'h77;
    reset = 1'b0;
    step();
    reset = 1'b1; upd_req = 1'b0;
    #1;
    chk("rst_anode", 32'(anode_n), 32'h3);
    chk("rst_idx",   32'(slot_idx), 32'd0);
    chk("rst_hex",   32'(hex_out), 32'd0);
    chk("rst_ack",   32'(upd_ack), 32'd0);
    repeat (FRAME) step();
    // randomized mask and handshake traffic for 100 frames
    for (int i = 0; i < 100 * FRAME; i++) begin
      en_mask = ND'($urandom);
      if (upd_req) begin
        if (upd_ack) upd_req = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        upd_req  = 1'b1;
        upd_vals = 8'($urandom);
      end
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
